// File: rtl/key_matrix_scan_if.sv
// Keypad-side signal bundle for key_matrix_scan: matrix lines plus debounced key event outputs.
interface key_matrix_scan_if;
    logic [3:0] key_row;
    logic [3:0] key_col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;
    logic       key_release;

    modport master (
        input  key_row,
        output key_col, key_code, key_valid, key_down, key_release
    );

    modport slave (
        output key_row,
        input  key_col, key_code, key_valid, key_down, key_release
    );
endinterface

// File: rtl/key_matrix_scan.sv
// 4x4 active-low keypad scanner: one-cold column drive, per-frame classification,
// and frame-level press/release debouncing with one-cycle event strobes.
module key_matrix_scan #(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned DEBOUNCE_CNT = 4
) (
    input logic               clk,
    input logic               resetn,
    key_matrix_scan_if.master kp
);
    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CNT + 1);

    typedef enum logic [1:0] {IDLE, PRESS_DEB, HELD, RELEASE_DEB} state_t;
    typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} frame_res_t;

    logic [3:0]       row_s1, row_s2;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       col_idx;
    logic [3:0]       key_col_q;
    logic [1:0]       acc_hits;
    logic [3:0]       acc_key;

    logic             sample, frame_end;
    logic [2:0]       col_hits;
    logic [1:0]       row_sel;
    logic [3:0]       hit_sum;
    logic [1:0]       new_hits;
    logic [3:0]       new_key;
    frame_res_t       frame_res;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic [3:0]       cand, cand_n;
    logic [3:0]       code_q, code_n;
    logic             down_q, down_n;
    logic             valid_q, valid_n;
    logic             release_q, release_n;

    assign sample    = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign frame_end = sample && (col_idx == 2'd3);

    // Hit count across the frame saturates at 2: only NONE/SINGLE/MULTI matters.
    always_comb begin
        col_hits = '0;
        row_sel  = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!row_s2[i]) begin
                col_hits = col_hits + 3'd1;
                row_sel  = 2'(i);
            end
        end
        hit_sum   = 4'(acc_hits) + 4'(col_hits);
        new_hits  = (hit_sum >= 4'd2) ? 2'd2 : hit_sum[1:0];
        new_key   = (col_hits == 3'd1) ? {row_sel, col_idx} : acc_key;
        frame_res = (new_hits == 2'd0) ? RES_NONE :
                    (new_hits == 2'd1) ? RES_SINGLE : RES_MULTI;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            row_s1    <= '1;
            row_s2    <= '1;
            div_cnt   <= '0;
            col_idx   <= '0;
            key_col_q <= 4'b1110;
            acc_hits  <= '0;
            acc_key   <= '0;
        end else begin
            row_s1 <= kp.key_row;
            row_s2 <= row_s1;
            if (sample) begin
                div_cnt   <= '0;
                col_idx   <= col_idx + 2'd1;
                key_col_q <= ~(4'b0001 << (col_idx + 2'd1));
                if (frame_end) begin
                    acc_hits <= '0;
                    acc_key  <= '0;
                end else begin
                    acc_hits <= new_hits;
                    acc_key  <= new_key;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            cand      <= '0;
            code_q    <= '0;
            down_q    <= 1'b0;
            valid_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cand      <= cand_n;
            code_q    <= code_n;
            down_q    <= down_n;
            valid_q   <= valid_n;
            release_q <= release_n;
        end
    end

    assign cnt_inc = cnt + 1'b1;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        cand_n    = cand;
        code_n    = code_q;
        down_n    = down_q;
        valid_n   = 1'b0;
        release_n = 1'b0;
        if (frame_end) begin
            unique case (state)
                IDLE: begin
                    if (frame_res == RES_SINGLE) begin
                        state_n = PRESS_DEB;
                        cand_n  = new_key;
                        cnt_n   = CNT_W'(1);
                    end
                end
                PRESS_DEB: begin
                    if (frame_res == RES_SINGLE) begin
                        if (new_key != cand) begin
                            cand_n = new_key;
                            cnt_n  = CNT_W'(1);
                        end else if (cnt_inc == CNT_W'(DEBOUNCE_CNT)) begin
                            state_n = HELD;
                            cnt_n   = '0;
                            code_n  = cand;
                            down_n  = 1'b1;
                            valid_n = 1'b1;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
                HELD: begin
                    if (frame_res == RES_NONE) begin
                        state_n = RELEASE_DEB;
                        cnt_n   = CNT_W'(1);
                    end
                end
                RELEASE_DEB: begin
                    if (frame_res != RES_NONE) begin
                        state_n = HELD;
                        cnt_n   = '0;
                    end else if (cnt_inc == CNT_W'(DEBOUNCE_CNT)) begin
                        state_n   = IDLE;
                        cnt_n     = '0;
                        down_n    = 1'b0;
                        release_n = 1'b1;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign kp.key_col     = key_col_q;
    assign kp.key_code    = code_q;
    assign kp.key_down    = down_q;
    assign kp.key_valid   = valid_q;
    assign kp.key_release = release_q;
endmodule

// File: tb/tb_key_matrix_scan.sv
// Directed bench for key_matrix_scan with SCAN_DIV=4, DEBOUNCE_CNT=3 and a passive keypad model.
module tb_key_matrix_scan;
    localparam int FRAME = 16;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] pressed = '0;   // bit {row,col}

    int errors = 0;
    int checks = 0;
    int cycle = 0;
    int valid_total = 0;
    int release_total = 0;
    int both_total = 0;
    int last_valid_cycle = 0;

    key_matrix_scan_if kif ();

    key_matrix_scan #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
        .clk    (clk),
        .resetn (resetn),
        .kp     (kif.master)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            kif.key_row[r] = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !kif.key_col[c]) kif.key_row[r] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        cycle <= cycle + 1;
        if (kif.key_valid) begin
            valid_total      <= valid_total + 1;
            last_valid_cycle <= cycle;
        end
        if (kif.key_release) release_total <= release_total + 1;
        if (kif.key_valid && kif.key_release) both_total <= both_total + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int v0, r0, t0;

        // Reset and column walk
        repeat (3) @(negedge clk);
        check("rst_col", 32'(kif.key_col), 32'h e);
        check("rst_code", 32'(kif.key_code), 32'h0);
        check("rst_valid", 32'(kif.key_valid), 32'h0);
        check("rst_down", 32'(kif.key_down), 32'h0);
        check("rst_release", 32'(kif.key_release), 32'h0);
        resetn = 1'b1;
        run_cycles(3);
        check("walk_col0", 32'(kif.key_col), 32'h e);
        run_cycles(1);
        check("walk_col1", 32'(kif.key_col), 32'h d);
        run_cycles(4);
        check("walk_col2", 32'(kif.key_col), 32'h b);
        run_cycles(4);
        check("walk_col3", 32'(kif.key_col), 32'h7);
        run_cycles(4);
        check("walk_wrap", 32'(kif.key_col), 32'h e);

        // Clean press of (2,1)
        v0 = valid_total; r0 = release_total; t0 = cycle;
        pressed = 16'h0200;
        run_cycles(10 * FRAME);
        check("press_valid_cnt", 32'(valid_total - v0), 32'd1);
        check("press_latency_ok", 32'((last_valid_cycle - t0 >= 30) && (last_valid_cycle - t0 <= 80)), 32'd1);
        check("press_code", 32'(kif.key_code), 32'h9);
        check("press_down", 32'(kif.key_down), 32'h1);

        // Release
        v0 = valid_total; r0 = release_total;
        pressed = '0;
        run_cycles(5 * FRAME);
        check("rel_release_cnt", 32'(release_total - r0), 32'd1);
        check("rel_no_valid", 32'(valid_total - v0), 32'd0);
        check("rel_down", 32'(kif.key_down), 32'h0);
        check("rel_code_held", 32'(kif.key_code), 32'h9);

        // One-frame release glitch while held
        pressed = 16'h0200;
        run_cycles(6 * FRAME);
        check("glitch_held", 32'(kif.key_down), 32'h1);
        r0 = release_total;
        pressed = '0;
        run_cycles(FRAME);
        pressed = 16'h0200;
        run_cycles(4 * FRAME);
        check("glitch_no_release", 32'(release_total - r0), 32'd0);
        check("glitch_down", 32'(kif.key_down), 32'h1);
        pressed = '0;
        run_cycles(5 * FRAME);
        check("glitch_final_release", 32'(release_total - r0), 32'd1);

        // Bounce of (1,3), one frame on / one frame off
        v0 = valid_total;
        for (int i = 0; i < 8; i++) begin
            pressed = (i % 2 == 0) ? 16'h0080 : 16'h0000;
            run_cycles(FRAME);
        end
        pressed = '0;
        run_cycles(4 * FRAME);
        check("bounce_no_valid", 32'(valid_total - v0), 32'd0);
        check("bounce_down", 32'(kif.key_down), 32'h0);

        // Ghost pair (0,0)+(3,3) from IDLE
        v0 = valid_total;
        pressed = 16'h8001;
        run_cycles(8 * FRAME);
        check("multi_no_valid", 32'(valid_total - v0), 32'd0);
        check("multi_down", 32'(kif.key_down), 32'h0);
        pressed = '0;
        run_cycles(2 * FRAME);

        // Hold key 5, then add (0,2)
        v0 = valid_total;
        pressed = 16'h0020;
        run_cycles(6 * FRAME);
        check("k5_valid_cnt", 32'(valid_total - v0), 32'd1);
        check("k5_code", 32'(kif.key_code), 32'h5);
        v0 = valid_total; r0 = release_total;
        pressed = 16'h0024;
        run_cycles(6 * FRAME);
        check("k5_add_no_valid", 32'(valid_total - v0), 32'd0);
        check("k5_add_no_release", 32'(release_total - r0), 32'd0);
        check("k5_add_code", 32'(kif.key_code), 32'h5);
        check("k5_add_down", 32'(kif.key_down), 32'h1);
        pressed = '0;
        run_cycles(6 * FRAME);
        check("k5_release_cnt", 32'(release_total - r0), 32'd1);

        // Reset during PRESS_DEB, key kept held
        v0 = valid_total; r0 = release_total;
        pressed = 16'h0200;
        run_cycles(36);
        check("mid_no_valid_yet", 32'(valid_total - v0), 32'd0);
        resetn = 1'b0;
        run_cycles(3);
        check("mid_rst_col", 32'(kif.key_col), 32'h e);
        check("mid_rst_code", 32'(kif.key_code), 32'h0);
        check("mid_rst_down", 32'(kif.key_down), 32'h0);
        check("mid_rst_no_pulse", 32'((valid_total - v0) + (release_total - r0)), 32'd0);
        resetn = 1'b1;
        run_cycles(40);
        check("mid_after_2frames_valid", 32'(valid_total - v0), 32'd0);
        check("mid_after_2frames_down", 32'(kif.key_down), 32'h0);
        run_cycles(FRAME);
        check("mid_after_3frames_valid", 32'(valid_total - v0), 32'd1);
        check("mid_after_3frames_code", 32'(kif.key_code), 32'h9);
        check("mid_after_3frames_down", 32'(kif.key_down), 32'h1);
        pressed = '0;
        run_cycles(5 * FRAME);

        check("never_both_pulses", 32'(both_total), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
